// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing controller for the 5-stage MIPS core. It resolves the
//   hazards that forwarding cannot cover:
//     - load-use: a one-cycle bubble into ID/EX;
//     - multi-cycle mult/div: freezes the front end and bubbles EX/M for
//       MD_LATENCY-1 cycles;
//     - taken branch: flushes IF/ID unless a stall holds it this cycle.
//   It also keeps a saturating count of the cycles in which the PC was frozen.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   ID_EX_memRead     EX instruction is a load
//   ID_EX_rt          destination register of that load
//   ID_EX_mdStart     EX instruction is mult/div
//   IF_ID_rs/rt       source registers of the ID instruction
//   IF_ID_useRt       ID instruction reads rt
//   branchTaken       branch/jump resolved taken in ID
//   pcWrite           PC update enable
//   IF_ID_write       IF/ID load enable
//   ID_EX_hold        ID/EX keeps its contents
//   ID_EX_bubble      ID/EX loads a NOP
//   EX_M_bubble       EX/M loads a NOP
//   IF_ID_flush       IF/ID loads a NOP
//   ctrlState         RUN=00, MD=01, RELEASE=10
//   stallCycles       saturating count of cycles with pcWrite=0
module hazard_controller #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_memRead,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_mdStart,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_useRt,
  input  logic        branchTaken,
  output logic        pcWrite,
  output logic        IF_ID_write,
  output logic        ID_EX_hold,
  output logic        ID_EX_bubble,
  output logic        EX_M_bubble,
  output logic        IF_ID_flush,
  output logic [1:0]  ctrlState,
  output logic [15:0] stallCycles
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_MD      = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  // RUN covers cycle 1 and RELEASE covers the last cycle, so the MD state
  // spans MD_LATENCY-2 cycles: counting down from MD_LATENCY-3 to 0.
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 3);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  // Register 0 is hardwired to zero and can never carry a hazard.
  assign load_use = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                    ((ID_EX_rt == IF_ID_rs) ||
                     (IF_ID_useRt && (ID_EX_rt == IF_ID_rt)));

  always_comb begin
    pcWrite      = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_hold   = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_M_bubble  = 1'b0;
    IF_ID_flush  = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;

    case (state)
      ST_RUN: begin
        if (ID_EX_mdStart) begin
          pcWrite     = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_hold  = 1'b1;
          EX_M_bubble = 1'b1;
          cnt_nxt     = MD_LOAD;
          state_nxt   = ST_MD;
        end else if (load_use) begin
          pcWrite      = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
        // A stalled IF/ID keeps the branch; it re-resolves next cycle.
        IF_ID_flush = branchTaken && pcWrite;
      end

      ST_MD: begin
        pcWrite     = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_hold  = 1'b1;
        EX_M_bubble = 1'b1;
        if (cnt == '0) begin
          state_nxt = ST_RELEASE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        // mdStart still shows the departing mult/div; ignore it here.
        IF_ID_flush = branchTaken;
        state_nxt   = ST_RUN;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (!rst_n) begin
      pcWrite      = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_hold   = 1'b0;
      ID_EX_bubble = 1'b0;
      EX_M_bubble  = 1'b0;
      IF_ID_flush  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cnt         <= '0;
      stallCycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pcWrite && (stallCycles != '1)) begin
        stallCycles <= stallCycles + 16'd1;
      end
    end
  end

  assign ctrlState = state;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ID_EX_memRead = 1'b0;
  logic [4:0]  ID_EX_rt = 5'd0;
  logic        ID_EX_mdStart = 1'b0;
  logic [4:0]  IF_ID_rs = 5'd0;
  logic [4:0]  IF_ID_rt = 5'd0;
  logic        IF_ID_useRt = 1'b0;
  logic        branchTaken = 1'b0;
  logic        pcWrite, IF_ID_write, ID_EX_hold, ID_EX_bubble;
  logic        EX_M_bubble, IF_ID_flush;
  logic [1:0]  ctrlState;
  logic [15:0] stallCycles;

  int tests = 0;
  int fails = 0;

  hazard_controller #(.MD_LATENCY(L), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_memRead(ID_EX_memRead), .ID_EX_rt(ID_EX_rt),
    .ID_EX_mdStart(ID_EX_mdStart), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .IF_ID_useRt(IF_ID_useRt),
    .branchTaken(branchTaken), .pcWrite(pcWrite),
    .IF_ID_write(IF_ID_write), .ID_EX_hold(ID_EX_hold),
    .ID_EX_bubble(ID_EX_bubble), .EX_M_bubble(EX_M_bubble),
    .IF_ID_flush(IF_ID_flush), .ctrlState(ctrlState),
    .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  // Model: m_p = cycles the current mult/div has already spent in EX
  // (0 = no mult/div in progress). m_sc = stall cycle count.
  int   m_p = 0;
  int   m_sc = 0;
  logic lu;
  logic exp_pc, exp_ifw, exp_hold, exp_bub, exp_exm, exp_flush;
  logic [1:0] exp_state;

  always_comb begin
    lu = ID_EX_memRead && (ID_EX_rt != 0) &&
         (ID_EX_rt == IF_ID_rs || (IF_ID_useRt && ID_EX_rt == IF_ID_rt));
    exp_pc = 1; exp_ifw = 1; exp_hold = 0; exp_bub = 0; exp_exm = 0;
    if (m_p == 0) exp_state = 2'b00;
    else if (m_p == L - 1) exp_state = 2'b10;
    else exp_state = 2'b01;
    if (rst_n) begin
      if ((m_p == 0 && ID_EX_mdStart) || (m_p > 0 && m_p < L - 1)) begin
        exp_pc = 0; exp_ifw = 0; exp_hold = 1; exp_exm = 1;
      end else if (m_p == 0 && lu) begin
        exp_pc = 0; exp_ifw = 0; exp_bub = 1;
      end
    end
    exp_flush = rst_n && branchTaken && exp_pc;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p  <= 0;
      m_sc <= 0;
    end else begin
      if (!exp_pc && m_sc < 65535) m_sc <= m_sc + 1;
      if (m_p == 0) m_p <= ID_EX_mdStart ? 1 : 0;
      else if (m_p == L - 1) m_p <= 0;
      else m_p <= m_p + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pcWrite", {31'd0, pcWrite}, {31'd0, exp_pc});
    chk("IF_ID_write", {31'd0, IF_ID_write}, {31'd0, exp_ifw});
    chk("ID_EX_hold", {31'd0, ID_EX_hold}, {31'd0, exp_hold});
    chk("ID_EX_bubble", {31'd0, ID_EX_bubble}, {31'd0, exp_bub});
    chk("EX_M_bubble", {31'd0, EX_M_bubble}, {31'd0, exp_exm});
    chk("IF_ID_flush", {31'd0, IF_ID_flush}, {31'd0, exp_flush});
    chk("ctrlState", {30'd0, ctrlState}, {30'd0, exp_state});
    chk("stallCycles", {16'd0, stallCycles}, m_sc);
  end

  task automatic clear_inputs();
    ID_EX_memRead = 0; ID_EX_rt = 0; ID_EX_mdStart = 0;
    IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_useRt = 0; branchTaken = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Mid-cycle sample point for directed checks.
  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    step();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  initial begin
    #1 rst_n = 0;
    #12 rst_n = 1;
    step();

    // Reset state
    mid();
    chk("rst_state", {30'd0, ctrlState}, 0);
    chk("rst_count", {16'd0, stallCycles}, 0);
    chk("rst_pc", {31'd0, pcWrite}, 1);

    // 1: load-use
    do_reset();
    ID_EX_memRead = 1; ID_EX_rt = 8; IF_ID_rs = 8;
    mid();
    chk("t1_pc", {31'd0, pcWrite}, 0);
    chk("t1_bubble", {31'd0, ID_EX_bubble}, 1);
    step();
    ID_EX_memRead = 0;
    mid();
    chk("t1_pc_after", {31'd0, pcWrite}, 1);
    chk("t1_count", {16'd0, stallCycles}, 1);

    // 2: register 0 and rt-use gating
    do_reset();
    ID_EX_memRead = 1; ID_EX_rt = 0; IF_ID_rs = 0;
    mid();
    chk("t2a_pc", {31'd0, pcWrite}, 1);
    step();
    ID_EX_rt = 9; IF_ID_rs = 3; IF_ID_rt = 9; IF_ID_useRt = 0;
    mid();
    chk("t2b_pc", {31'd0, pcWrite}, 1);
    step();
    IF_ID_useRt = 1;
    mid();
    chk("t2c_pc", {31'd0, pcWrite}, 0);
    step();
    ID_EX_memRead = 0;
    mid();
    chk("t2c_count", {16'd0, stallCycles}, 1);

    // 3: single mult/div
    do_reset();
    ID_EX_mdStart = 1;
    mid();
    chk("t3_s0", {30'd0, ctrlState}, 0);
    chk("t3_exm0", {31'd0, EX_M_bubble}, 1);
    step(); mid();
    chk("t3_s1", {30'd0, ctrlState}, 1);
    step(); mid();
    chk("t3_s2", {30'd0, ctrlState}, 1);
    chk("t3_pc2", {31'd0, pcWrite}, 0);
    step(); mid();
    chk("t3_s3", {30'd0, ctrlState}, 2);
    chk("t3_pc3", {31'd0, pcWrite}, 1);
    chk("t3_exm3", {31'd0, EX_M_bubble}, 0);
    step();
    ID_EX_mdStart = 0;
    mid();
    chk("t3_s4", {30'd0, ctrlState}, 0);
    chk("t3_count", {16'd0, stallCycles}, 3);

    // 4: branch during load-use stall
    do_reset();
    ID_EX_memRead = 1; ID_EX_rt = 8; IF_ID_rs = 8; branchTaken = 1;
    mid();
    chk("t4_flush0", {31'd0, IF_ID_flush}, 0);
    step();
    ID_EX_memRead = 0;
    mid();
    chk("t4_flush1", {31'd0, IF_ID_flush}, 1);

    // 5: back-to-back mult/div
    do_reset();
    ID_EX_mdStart = 1;
    repeat (4) step();
    mid();
    chk("t5_s4", {30'd0, ctrlState}, 0);
    chk("t5_pc4", {31'd0, pcWrite}, 0);
    step(); mid();
    chk("t5_s5", {30'd0, ctrlState}, 1);
    step(); step();
    mid();
    chk("t5_s7", {30'd0, ctrlState}, 2);
    step();
    ID_EX_mdStart = 0;
    mid();
    chk("t5_count", {16'd0, stallCycles}, 6);

    // 6: reset in the second MD cycle
    do_reset();
    ID_EX_mdStart = 1;
    step(); step();
    rst_n = 0;
    #1;
    chk("t6_state", {30'd0, ctrlState}, 0);
    chk("t6_pc", {31'd0, pcWrite}, 1);
    chk("t6_count", {16'd0, stallCycles}, 0);
    ID_EX_mdStart = 0;
    #1 rst_n = 1;
    step();

    // 7: saturation
    do_reset();
    ID_EX_memRead = 1; ID_EX_rt = 8; IF_ID_rs = 8;
    repeat (65540) step();
    mid();
    chk("t7_sat", {16'd0, stallCycles}, 32'h0000FFFF);
    step(); mid();
    chk("t7_hold", {16'd0, stallCycles}, 32'h0000FFFF);
    clear_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
